bus_synchronizer: RTL and testbench

// - Brings a multi-bit, gray-coded bus from a foreign clock domain into the clk domain.
// - Each bit passes through its own chain of STAGE_COUNT flip-flops to resolve metastability.
// - Sits at clock-domain-crossing boundaries, e.g. gray-coded FIFO read/write pointers.
// - Correct only when the source changes at most one bit per update and holds each value
//   for at least STAGE_COUNT destination clock periods.
//

---
 rtl/cdc_pkg.sv | 6 +
 rtl/bit_synchronizer.sv | 31 +++
 rtl/bus_synchronizer.sv | 34 +++
 tb/tb_bus_synchronizer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared constants for the clock-domain-crossing synchronizers.
package cdc_pkg;
    localparam int CDC_STAGE_COUNT = 2;
    localparam int CDC_BUS_WIDTH   = 4;
    localparam int CDC_MIN_STAGES  = 2;
endpackage

// File: rtl/bit_synchronizer.sv
// Single-bit STAGE_COUNT-deep synchronizer chain with asynchronous active-low clear.
module bit_synchronizer
    import cdc_pkg::*;
#(
    parameter int STAGE_COUNT = CDC_STAGE_COUNT
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGE_COUNT-1:0] chain_d;
    (* ASYNC_REG = "TRUE" *) logic [STAGE_COUNT-1:0] chain_q;

    // Bit 0 samples the foreign-domain input; each later bit takes its predecessor.
    always_comb begin
        chain_d = {chain_q[STAGE_COUNT-2:0], d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGE_COUNT-1];

endmodule

// File: rtl/bus_synchronizer.sv
// Gray-coded bus synchronizer: one independent flop chain per bit, no handshake or enable.
module bus_synchronizer
    import cdc_pkg::*;
#(
    parameter int STAGE_COUNT = CDC_STAGE_COUNT,
    parameter int BUS_WIDTH   = CDC_BUS_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUS_WIDTH-1:0] asynchronous_data,
    output logic [BUS_WIDTH-1:0] synchronous_data
);

    if (STAGE_COUNT < CDC_MIN_STAGES) begin : g_bad_stage_count
        $error("bus_synchronizer: STAGE_COUNT must be at least %0d", CDC_MIN_STAGES);
    end

    if (BUS_WIDTH < 1) begin : g_bad_bus_width
        $error("bus_synchronizer: BUS_WIDTH must be at least 1");
    end

    // Bits are synchronized independently; coherence relies on the source changing one bit at a time.
    for (genvar i = 0; i < BUS_WIDTH; i++) begin : g_bit
        bit_synchronizer #(
            .STAGE_COUNT(STAGE_COUNT)
        ) u_bit_sync (
            .clk  (clk),
            .reset(reset),
            .d    (asynchronous_data[i]),
            .q    (synchronous_data[i])
        );
    end

endmodule

// File: tb/tb_bus_synchronizer.sv
// Bench for bus_synchronizer: default 4-bit/2-stage instance plus an 8-bit/3-stage instance.
module tb_bus_synchronizer;

    logic       clk;
    logic       reset;
    logic [3:0] data_n;
    logic [3:0] sync_n;
    logic [7:0] data_w;
    logic [7:0] sync_w;

    int checks;
    int errors;
    int edge_cnt;

    logic [3:0] exp_q[$];
    logic [7:0] exp_w_q[$];
    int         lat_q[$];

    logic       mon_en;
    logic [3:0] mon_prev;

    bus_synchronizer u_dut_n (
        .clk              (clk),
        .reset            (reset),
        .asynchronous_data(data_n),
        .synchronous_data (sync_n)
    );

    bus_synchronizer #(
        .STAGE_COUNT(3),
        .BUS_WIDTH  (8)
    ) u_dut_w (
        .clk              (clk),
        .reset            (reset),
        .asynchronous_data(data_w),
        .synchronous_data (sync_w)
    );

    // Clock and reset: 12 ns period, rising edges at 6, 18, 30, ...
    initial begin
        clk = 1'b0;
        forever #6 clk = ~clk;
    end

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    // Sweep monitor: every output change must be the next queued code, 2 edges after its input change.
    always @(posedge clk) begin
        #1;
        if (mon_en && sync_n !== mon_prev) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL sweep_glitch: output %b changed with nothing expected", sync_n);
            end else begin
                logic [3:0] e;
                int         l;
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                if (sync_n !== e) begin
                    errors = errors + 1;
                    $display("FAIL sweep_value: got %b expected %b", sync_n, e);
                end
                checks = checks + 1;
                if (edge_cnt - l != 2) begin
                    errors = errors + 1;
                    $display("FAIL sweep_latency: got %0d edges expected 2", edge_cnt - l);
                end
            end
            mon_prev = sync_n;
        end
    end

    task automatic test_reset();
        reset  = 1'b0;
        data_n = 4'b0000;
        data_w = 8'h00;
        #12;
        checks = checks + 1;
        if (sync_n !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL reset_narrow: got %b expected 0000", sync_n);
        end
        checks = checks + 1;
        if (sync_w !== 8'h00) begin
            errors = errors + 1;
            $display("FAIL reset_wide: got %h expected 00", sync_w);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_latency();
        logic [3:0] en;
        logic [7:0] ew;
        @(posedge clk);
        #1;
        data_n = 4'b0001;
        data_w = 8'h80;
        exp_q.push_back(4'b0001);
        exp_w_q.push_back(8'h80);
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (sync_n !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL latency_edge1_narrow: got %b expected 0000", sync_n);
        end
        checks = checks + 1;
        if (sync_w !== 8'h00) begin
            errors = errors + 1;
            $display("FAIL latency_edge1_wide: got %h expected 00", sync_w);
        end
        @(posedge clk);
        #1;
        en = exp_q.pop_front();
        checks = checks + 1;
        if (sync_n !== en) begin
            errors = errors + 1;
            $display("FAIL latency_edge2_narrow: got %b expected %b", sync_n, en);
        end
        checks = checks + 1;
        if (sync_w !== 8'h00) begin
            errors = errors + 1;
            $display("FAIL latency_edge2_wide: got %h expected 00", sync_w);
        end
        @(posedge clk);
        #1;
        ew = exp_w_q.pop_front();
        checks = checks + 1;
        if (sync_w !== ew) begin
            errors = errors + 1;
            $display("FAIL latency_edge3_wide: got %h expected %h", sync_w, ew);
        end
    endtask

    task automatic test_sweep();
        logic [3:0] seq [16];
        seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        data_n = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        checks = checks + 1;
        if (sync_n !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL sweep_start: got %b expected 0000", sync_n);
        end
        mon_prev = sync_n;
        mon_en   = 1'b1;
        @(posedge clk);
        #3;
        for (int i = 0; i < 16; i++) begin
            data_n = seq[i];
            exp_q.push_back(seq[i]);
            lat_q.push_back(edge_cnt);
            #30;
        end
        repeat (4) @(posedge clk);
        #2;
        mon_en = 1'b0;
        checks = checks + 1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL sweep_drain: %0d codes never appeared, expected 0", exp_q.size());
        end
        exp_q.delete();
        lat_q.delete();
    endtask

    task automatic test_mid_reset();
        logic [3:0] e;
        data_n = 4'b0110;
        exp_q.push_back(4'b0110);
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks = checks + 1;
        if (sync_n !== e) begin
            errors = errors + 1;
            $display("FAIL midreset_before: got %b expected %b", sync_n, e);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks = checks + 1;
        if (sync_n !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL midreset_clear_narrow: got %b expected 0000", sync_n);
        end
        checks = checks + 1;
        if (sync_w !== 8'h00) begin
            errors = errors + 1;
            $display("FAIL midreset_clear_wide: got %h expected 00", sync_w);
        end
        #1;
        reset = 1'b1;
        exp_q.push_back(4'b0110);
        @(posedge clk);
        #1;
        checks = checks + 1;
        if (sync_n !== 4'b0000) begin
            errors = errors + 1;
            $display("FAIL midreset_edge1: got %b expected 0000", sync_n);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks = checks + 1;
        if (sync_n !== e) begin
            errors = errors + 1;
            $display("FAIL midreset_edge2: got %b expected %b", sync_n, e);
        end
    endtask

    task automatic test_stable();
        logic [3:0] e;
        int         hold;
        hold   = $urandom_range(10, 12);
        data_n = 4'b1011;
        exp_q.push_back(4'b1011);
        repeat (2) @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks = checks + 1;
        if (sync_n !== e) begin
            errors = errors + 1;
            $display("FAIL stable_arrive: got %b expected %b", sync_n, e);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checks = checks + 1;
            if (sync_n !== 4'b1011) begin
                errors = errors + 1;
                $display("FAIL stable_hold: cycle %0d got %b expected 1011", i, sync_n);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        mon_prev = 4'b0000;
        test_reset();
        test_latency();
        test_sweep();
        test_mid_reset();
        test_stable();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
